// File: rtl/difftest_vec_csr_tracker.sv
// Vector-CSR difftest tracker.
// Keeps a shadow copy of the vector CSRs and applies up to NUM_CH commit
// writes per cycle, with vcsr = {vxrm, vxsat} aliasing. Every state change
// or forced snapshot queues a sequence-numbered entry. Entries drain over a
// valid/ready port.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   wr_valid/wr_sel/wr_data - per-channel commit CSR writes (channel 0 first)
//   force_snap              - queue a snapshot even without a change
//   out_valid/out_ready     - snapshot FIFO head handshake
//   out_v*                  - head snapshot CSR values (zero when empty)
//   out_coreid, out_seq     - core id and snapshot sequence number
//   drop_cnt, overflow      - saturating drop count, sticky drop flag
module difftest_vec_csr_tracker #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 8,
  parameter logic [63:0] VLENB  = 64'd16,
  parameter logic [7:0]  COREID = 8'd0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      wr_valid,
  input  logic [3*NUM_CH-1:0]    wr_sel,
  input  logic [64*NUM_CH-1:0]   wr_data,
  input  logic                   force_snap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_vstart,
  output logic [63:0]            out_vxsat,
  output logic [63:0]            out_vxrm,
  output logic [63:0]            out_vcsr,
  output logic [63:0]            out_vl,
  output logic [63:0]            out_vtype,
  output logic [63:0]            out_vlenb,
  output logic [7:0]             out_coreid,
  output logic [31:0]            out_seq,
  output logic [31:0]            drop_cnt,
  output logic                   overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // vcsr is not stored: it is always {vxrm, vxsat}. vlenb is constant.
  typedef struct packed {
    logic [63:0] vstart;
    logic        vxsat;
    logic [1:0]  vxrm;
    logic [63:0] vl;
    logic [63:0] vtype;
  } shadow_t;

  typedef struct packed {
    shadow_t     sh;
    logic [31:0] seq;
  } snap_t;

  shadow_t          sh_q, sh_d;
  snap_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      seq_q, drop_q;
  logic             ovf_q;

  logic push_c, pop_c, full_c, accept_c, drop_c;
  snap_t head_c;

  // Apply channel writes in index order; later channels see earlier results.
  always_comb begin
    sh_d = sh_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_valid[i]) begin
        case (wr_sel[3*i +: 3])
          3'd0: sh_d.vstart = wr_data[64*i +: 64];
          3'd1: sh_d.vxsat  = wr_data[64*i];
          3'd2: sh_d.vxrm   = wr_data[64*i +: 2];
          3'd3: begin
            sh_d.vxsat = wr_data[64*i];
            sh_d.vxrm  = wr_data[64*i+1 +: 2];
          end
          3'd4: sh_d.vl     = wr_data[64*i +: 64];
          3'd5: sh_d.vtype  = wr_data[64*i +: 64];
          default: ;  // vlenb is read-only, 7 is reserved
        endcase
      end
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push.
  always_comb begin
    push_c   = (sh_d != sh_q) | force_snap;
    pop_c    = out_valid & out_ready;
    full_c   = (cnt_q == CNT_W'(DEPTH));
    accept_c = push_c & (~full_c | pop_c);
    drop_c   = push_c & full_c & ~pop_c;
    cnt_d    = cnt_q;
    if (accept_c && !pop_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept_c && pop_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q     <= '{vstart: 64'd0, vxsat: 1'b0, vxrm: 2'd0, vl: 64'd0,
                    vtype: 64'h8000_0000_0000_0000};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      if (accept_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c)   seq_q    <= seq_q + 32'd1;
      if (drop_c) begin
        ovf_q <= 1'b1;
        if (drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    if (!reset && accept_c) begin
      mem_q[wr_ptr_q] <= '{sh: sh_d, seq: seq_q};
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign head_c     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_vstart = head_c.sh.vstart;
  assign out_vxsat  = 64'(head_c.sh.vxsat);
  assign out_vxrm   = 64'(head_c.sh.vxrm);
  assign out_vcsr   = 64'({head_c.sh.vxrm, head_c.sh.vxsat});
  assign out_vl     = head_c.sh.vl;
  assign out_vtype  = head_c.sh.vtype;
  assign out_vlenb  = out_valid ? VLENB : 64'd0;
  assign out_coreid = COREID;
  assign out_seq    = head_c.seq;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_difftest_vec_csr_tracker.sv
module tb_difftest_vec_csr_tracker;

  logic          clock, reset, force_snap, out_ready, out_valid, overflow;
  logic [1:0]    wr_valid;
  logic [5:0]    wr_sel;
  logic [127:0]  wr_data;
  logic [63:0]   out_vstart, out_vxsat, out_vxrm, out_vcsr, out_vl, out_vtype, out_vlenb;
  logic [7:0]    out_coreid;
  logic [31:0]   out_seq, drop_cnt;

  difftest_vec_csr_tracker dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_sel(wr_sel),
    .wr_data(wr_data), .force_snap(force_snap), .out_valid(out_valid),
    .out_ready(out_ready), .out_vstart(out_vstart), .out_vxsat(out_vxsat),
    .out_vxrm(out_vxrm), .out_vcsr(out_vcsr), .out_vl(out_vl),
    .out_vtype(out_vtype), .out_vlenb(out_vlenb), .out_coreid(out_coreid),
    .out_seq(out_seq), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: CSRs indexed by their select code 0..6.
  typedef struct packed {
    logic [6:0][63:0] v;
    logic [31:0]      seq;
  } snap_t;

  logic [6:0][63:0] m_csr, post;
  snap_t            m_q[$];
  snap_t            s;
  logic [31:0]      m_seq, m_drop;
  logic             m_ovf;
  bit               started = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_csr = '0;
      m_csr[5] = 64'h8000_0000_0000_0000;
      m_csr[6] = 64'd16;
      m_q.delete();
      m_seq = 0; m_drop = 0; m_ovf = 0;
      started = 1;
    end else if (started) begin
      post = m_csr;
      for (int c = 0; c < 2; c++) begin
        if (wr_valid[c]) begin
          logic [63:0] d;
          d = wr_data[64*c +: 64];
          case (wr_sel[3*c +: 3])
            3'd0: post[0] = d;
            3'd1: begin post[1] = d & 64'h1; post[3] = (post[2] << 1) | post[1]; end
            3'd2: begin post[2] = d & 64'h3; post[3] = (post[2] << 1) | post[1]; end
            3'd3: begin post[3] = d & 64'h7; post[1] = d & 64'h1; post[2] = (d >> 1) & 64'h3; end
            3'd4: post[4] = d;
            3'd5: post[5] = d;
            default: ;
          endcase
        end
      end
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if ((post != m_csr) || force_snap) begin
        if (m_q.size() < 8) begin
          s.v = post; s.seq = m_seq;
          m_q.push_back(s);
        end else begin
          m_ovf = 1;
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end
        m_seq++;
      end
      m_csr = post;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clock) begin
    if (started) begin
      snap_t e;
      e = (m_q.size() != 0) ? m_q[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      chk("out_vstart", out_vstart, e.v[0]);
      chk("out_vxsat", out_vxsat, e.v[1]);
      chk("out_vxrm", out_vxrm, e.v[2]);
      chk("out_vcsr", out_vcsr, e.v[3]);
      chk("out_vl", out_vl, e.v[4]);
      chk("out_vtype", out_vtype, e.v[5]);
      chk("out_vlenb", out_vlenb, e.v[6]);
      chk("out_seq", 64'(out_seq), 64'(e.seq));
      chk("out_coreid", 64'(out_coreid), 64'd0);
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic step(input logic rst, input logic [1:0] wv, input logic [5:0] ws,
                      input logic [127:0] wd, input logic fs, input logic rdy);
    reset = rst; wr_valid = wv; wr_sel = ws; wr_data = wd;
    force_snap = fs; out_ready = rdy;
    @(negedge clock);
  endtask

  task automatic wr1(input logic [2:0] sel, input logic [63:0] d, input logic rdy);
    step(1'b0, 2'b01, {3'd0, sel}, {64'd0, d}, 1'b0, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, 6'd0, 128'd0, 1'b0, rdy);
  endtask

  task automatic force1();
    step(1'b0, 2'b00, 6'd0, 128'd0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_valid = '0; wr_sel = '0; wr_data = '0;
    force_snap = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    step(1'b1, 2'b00, 6'd0, 128'd0, 1'b0, 1'b0);

    // Idle after reset, then a forced snapshot of the reset state.
    idle(1'b0);
    chk("lit idle valid", 64'(out_valid), 64'd0);
    chk("lit idle drop", 64'(drop_cnt), 64'd0);
    force1();
    chk("lit force valid", 64'(out_valid), 64'd1);
    chk("lit force vlenb", out_vlenb, 64'd16);
    chk("lit force seq", 64'(out_seq), 64'd0);
    chk("lit force vtype", out_vtype, 64'h8000_0000_0000_0000);
    idle(1'b1);
    chk("lit drained", 64'(out_valid), 64'd0);

    // Same-cycle conflict on vl: channel 1 wins.
    step(1'b0, 2'b11, {3'd4, 3'd4}, {64'd9, 64'd5}, 1'b0, 1'b0);
    chk("lit conflict vl", out_vl, 64'd9);
    chk("lit conflict seq", 64'(out_seq), 64'd1);
    idle(1'b1);

    // Aliasing between vcsr, vxsat and vxrm.
    wr1(3'd3, 64'h5, 1'b0);
    chk("lit vcsr->vxsat", out_vxsat, 64'd1);
    chk("lit vcsr->vxrm", out_vxrm, 64'd2);
    idle(1'b1);
    wr1(3'd2, 64'h3, 1'b0);
    chk("lit vxrm->vcsr", out_vcsr, 64'h7);
    chk("lit vxrm seq", 64'(out_seq), 64'd3);
    idle(1'b1);
    wr1(3'd6, 64'hFF, 1'b0);
    chk("lit vlenb write no push", 64'(out_valid), 64'd0);
    force1();
    chk("lit vlenb kept", out_vlenb, 64'd16);
    chk("lit vlenb seq", 64'(out_seq), 64'd4);
    idle(1'b1);

    // Same-value write is not a change.
    wr1(3'd4, 64'd9, 1'b0);
    chk("lit nochange valid", 64'(out_valid), 64'd0);
    force1();
    chk("lit nochange seq", 64'(out_seq), 64'd5);
    idle(1'b1);

    // Overflow: 10 pushes into 8 slots.
    step(1'b1, 2'b00, 6'd0, 128'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) wr1(3'd0, 64'(i), 1'b0);
    chk("lit ovf drop", 64'(drop_cnt), 64'd2);
    chk("lit ovf flag", 64'(overflow), 64'd1);
    chk("lit ovf head seq", 64'(out_seq), 64'd0);
    // Full with simultaneous push and pop: nothing dropped.
    wr1(3'd0, 64'd100, 1'b1);
    chk("lit full pushpop drop", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 8; k++) begin
      chk("lit drain valid", 64'(out_valid), 64'd1);
      chk("lit drain seq", 64'(out_seq), (k < 7) ? 64'(k + 1) : 64'd10);
      idle(1'b1);
    end
    chk("lit drain empty", 64'(out_valid), 64'd0);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++) wr1(3'd0, 64'(200 + i), 1'b0);
    chk("lit queued", 64'(out_valid), 64'd1);
    step(1'b1, 2'b00, 6'd0, 128'd0, 1'b0, 1'b0);
    chk("lit rst valid", 64'(out_valid), 64'd0);
    chk("lit rst ovf", 64'(overflow), 64'd0);
    chk("lit rst drop", 64'(drop_cnt), 64'd0);
    force1();
    chk("lit rst seq", 64'(out_seq), 64'd0);
    idle(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [127:0] d;
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) == 0) d[64*c +: 64] = {$urandom, $urandom};
        else d[64*c +: 64] = 64'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 199) == 0), 2'($urandom), 6'($urandom), d,
           ($urandom_range(0, 9) == 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
